// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared word type, next-PC opcodes and PC defaults for the fetch unit
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    NPC_SEQ = 3'b000,
    NPC_BR  = 3'b001,
    NPC_J   = 3'b010,
    NPC_JR  = 3'b011
  } npc_op_e;

  localparam word_t RESET_PC_DEF   = 32'h0000_3000;
  localparam word_t IMEM_BASE_DEF  = 32'h0000_3000;
  localparam word_t EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - redirect/stall inputs and fetch-PC outputs of the fetch unit
interface pc_fetch_unit_if;
  import cpu_pkg::*;

  logic        stall;
  logic [2:0]  npc_op;
  logic        br_taken;
  word_t       pc_id;
  word_t       imm_ext;
  logic [25:0] j_index;
  word_t       reg_target;
  logic        exc_req;
  logic        eret_req;
  word_t       epc;
  word_t       pc_f;
  word_t       pc_link;
  logic        adel_f;
  logic        redirect;

  modport master (
    output stall, npc_op, br_taken, pc_id, imm_ext, j_index, reg_target,
           exc_req, eret_req, epc,
    input  pc_f, pc_link, adel_f, redirect
  );

  modport slave (
    input  stall, npc_op, br_taken, pc_id, imm_ext, j_index, reg_target,
           exc_req, eret_req, epc,
    output pc_f, pc_link, adel_f, redirect
  );

endinterface

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational branch/jump/jr target selection relative to the ID-stage PC
module pc_target_calc
  import cpu_pkg::*;
(
  input  logic [2:0]  npc_op_i,
  input  logic        br_taken_i,
  input  word_t       pc_id_i,
  input  word_t       imm_ext_i,
  input  logic [25:0] j_index_i,
  input  word_t       reg_target_i,
  output word_t       target_o,
  output logic        take_o
);

  word_t pc_id_p4;

  assign pc_id_p4 = pc_id_i + 32'd4;

  // take_o low means the top falls back to pc_f + 4 (includes branch not taken)
  always_comb begin
    target_o = pc_id_p4;
    take_o   = 1'b0;
    case (npc_op_i)
      NPC_BR: begin
        if (br_taken_i) begin
          target_o = pc_id_p4 + (imm_ext_i << 2);
          take_o   = 1'b1;
        end
      end
      NPC_J: begin
        target_o = {pc_id_p4[31:28], j_index_i, 2'b00};
        take_o   = 1'b1;
      end
      NPC_JR: begin
        target_o = reg_target_i;
        take_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC register with stall, redirect priority and adel_f check; PC_FETCH_EXC_EN adds exception/eret entry
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t       RESET_PC   = RESET_PC_DEF,
  parameter word_t       IMEM_BASE  = IMEM_BASE_DEF,
  parameter int unsigned IMEM_WORDS = 4096,
  parameter word_t       EXC_VECTOR = EXC_VECTOR_DEF
)
(
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.slave  bus
);

  localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + {IMEM_WORDS[30:0], 2'b00};

  word_t pc_f_q, pc_f_d;
  logic  redirect_q, redirect_d;
  word_t seq_pc;
  word_t tgt;
  logic  take;

  assign seq_pc = pc_f_q + 32'd4;

  pc_target_calc u_target_calc (
    .npc_op_i     (bus.npc_op),
    .br_taken_i   (bus.br_taken),
    .pc_id_i      (bus.pc_id),
    .imm_ext_i    (bus.imm_ext),
    .j_index_i    (bus.j_index),
    .reg_target_i (bus.reg_target),
    .target_o     (tgt),
    .take_o       (take)
  );

  // Later assignments win: exception entry overrides stall, stall overrides ID redirects
  always_comb begin
    pc_f_d     = seq_pc;
    redirect_d = 1'b0;
    if (bus.stall) begin
      pc_f_d     = pc_f_q;
      redirect_d = redirect_q;
    end else if (take) begin
      pc_f_d     = tgt;
      redirect_d = (tgt != seq_pc);
    end
`ifdef PC_FETCH_EXC_EN
    if (bus.exc_req) begin
      pc_f_d     = EXC_VECTOR;
      redirect_d = 1'b1;
    end else if (bus.eret_req) begin
      pc_f_d     = bus.epc;
      redirect_d = 1'b1;
    end
`endif
  end

`ifndef PC_FETCH_EXC_EN
  logic unused_exc;
  assign unused_exc = ^{bus.exc_req, bus.eret_req, bus.epc, EXC_VECTOR};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q     <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.pc_f     = pc_f_q;
  assign bus.redirect = redirect_q;
  assign bus.pc_link  = bus.pc_id + 32'd8;
  assign bus.adel_f   = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IMEM_BASE) ||
                        ({1'b0, pc_f_q} >= IMEM_LIMIT);

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Pipelined successor to the single-cycle next-PC logic. Owns the fetch PC register for the 5-stage MIPS core.
- Takes the redirect decision from the ID stage and computes branch, jump and register targets relative to the ID-stage PC. MIPS delay-slot semantics apply.
- Applies stall and checks fetch address legality.
- Sits between the hazard unit/ID-stage comparator and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_BASE, 32'h0000_3000, first legal fetch address.
- IMEM_WORDS, 4096, number of legal instruction words starting at IMEM_BASE.
- EXC_VECTOR, 32'h0000_4180, exception entry address (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold the PC this cycle.
- npc_op  input  3  ID-stage redirect kind: 000 seq, 001 branch, 010 jump, 011 jr, others treated as seq.
- br_taken  input  1  ID-stage comparator result; qualifies npc_op=001.
- pc_id  input  32  PC of the instruction currently in ID.
- imm_ext  input  32  sign-extended 16-bit branch offset (words).
- j_index  input  26  jump instr_index field.
- reg_target  input  32  forwarded rs value for jr/jalr.
- exc_req  input  1  take exception (optional feature only).
- eret_req  input  1  return from exception (optional feature only).
- epc  input  32  return address for eret (optional feature only).
- pc_f  output  32  current fetch PC (registered).
- pc_link  output  32  pc_id + 8, the link value for jal/jalr.
- adel_f  output  1  fetch address error for pc_f (combinational from pc_f).
- redirect  output  1  registered: the previous PC update was non-sequential.

Behaviour:
- Reset (asynchronous, reset=1): pc_f=RESET_PC, redirect=0. Release takes effect at the next rising edge; no partial update.
- All arithmetic is 32-bit modulo 2^32. Wrap-around is not flagged as an error by itself; adel_f covers it via the range check.
- Target computation, all relative to pc_id:
  - branch: pc_id + 4 + (imm_ext << 2)
  - jump: {pc_id+4 [31:28], j_index, 2'b00}
  - jr: reg_target, used unmodified even if misaligned
- Next-PC priority, highest first:
  1. reset
  2. exc_req / eret_req (optional feature)
  3. stall
  4. npc_op=001 with br_taken=1 → branch target
  5. npc_op=010 → jump target
  6. npc_op=011 → jr target
  7. otherwise pc_f + 4
- Delay slot: when ID redirects, pc_f already holds the delay-slot address pc_id+4. That instruction is not flushed; the redirect target is loaded at the next edge.
- Stall: pc_f and redirect hold their values. A redirect presented during a stall is discarded. ID is frozen by the same stall, so the redirect is re-presented afterwards.
- Branch not taken (001 with br_taken=0): sequential, redirect=0.
- redirect <= 1 on any clocked update not equal to pc_f+4 from cases 2 or 4-6; else 0.
- adel_f=1 when pc_f[1:0]!=0, or pc_f<IMEM_BASE, or pc_f>=IMEM_BASE+4*IMEM_WORDS. The PC still advances normally; the exception logic decides what to do.
- pc_link = pc_id + 8, combinational.

Optional Feature:
- Macro PC_FETCH_EXC_EN.
- Defined:
  - exc_req=1 loads EXC_VECTOR; else eret_req=1 loads epc. exc_req wins over eret_req.
  - Both override stall and ID redirects, and set redirect=1.
- Undefined:
  - exc_req, eret_req and epc are still present as ports but ignored.
  - EXC_VECTOR is unused.

Decomposition:
- Shared package cpu_pkg: npc_op encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR), RESET_PC/EXC_VECTOR defaults, and the 32-bit word type.
- One natural sub-module, pc_target_calc: purely combinational target selection from npc_op, br_taken, pc_id, imm_ext, j_index and reg_target.
- Register, stall, priority and adel_f logic stay in the top.

Test Plan:
- Reset then 3 free-running cycles → pc_f 0x3000, 0x3004, 0x3008, 0x300C; redirect=0; adel_f=0.
- pc_id=0x3004, npc_op=001, br_taken=1, imm_ext=0xFFFF_FFFE → next pc_f=0x3000, redirect=1. With br_taken=0 → pc_f=0x300C, redirect=0.
- npc_op=010, j_index=0x0000C10, pc_id=0x3010 → pc_f=0x0000_3040. Same stimulus with stall=1 → pc_f unchanged, redirect held.
- npc_op=011, reg_target=0x0000_3002 → pc_f=0x3002, adel_f=1. reg_target=0x0000_7000 with IMEM_WORDS=4096 → adel_f=1.
- Assert reset asynchronously mid-cycle during a taken branch → pc_f=0x3000 immediately, before the next edge, and redirect=0.
- With PC_FETCH_EXC_EN: exc_req=1 and stall=1 with npc_op=010 → pc_f=0x4180. Next cycle eret_req=1, epc=0x3100 → pc_f=0x3100.
